// File: rtl/add8u_err_sweeper.sv
// Error-metric sweeper for an external approximate unsigned adder: walks every
// (A,B) pair and accumulates MAE/WCE/EP/MSE statistics against the exact sum.
module add8u_err_sweeper #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [3*W:0]     mae_sum,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output logic [2*W:0]     err_count,
  output logic [4*W+2:0]   mse_sum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*W-1:0]     k_q, k_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               valid_q, valid_d;
  logic [W:0]         stg_err_q, stg_err_d;
  logic [W-1:0]       stg_a_q, stg_a_d;
  logic [W-1:0]       stg_b_q, stg_b_d;

  logic [3*W:0]       mae_q, mae_d;
  logic [4*W+2:0]     mse_q, mse_d;
  logic [2*W:0]       cnt_q, cnt_d;
  logic [W:0]         wce_q, wce_d;
  logic [W-1:0]       wce_a_q, wce_a_d;
  logic [W-1:0]       wce_b_q, wce_b_d;

  logic [W:0]         exact_sum;
  logic [W:0]         abs_err;
  logic [2*W+1:0]     err_sq;

  // A sweeps fastest: the low half of the pair index drives operand A.
  assign op_a = k_q[W-1:0];
  assign op_b = k_q[2*W-1:W];

  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
  assign abs_err   = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                               : (exact_sum - approx_sum);
  assign err_sq    = {{(W+1){1'b0}}, stg_err_q} * {{(W+1){1'b0}}, stg_err_q};

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    stg_err_d = stg_err_q;
    stg_a_d   = stg_a_q;
    stg_b_d   = stg_b_q;
    mae_d     = mae_q;
    mse_d     = mse_q;
    cnt_d     = cnt_q;
    wce_d     = wce_q;
    wce_a_d   = wce_a_q;
    wce_b_d   = wce_b_q;

    // The staged pair is folded in on every edge it is valid, abort included.
    if (valid_q) begin
      mae_d = mae_q + {{(2*W){1'b0}}, stg_err_q};
      mse_d = mse_q + {{(2*W+1){1'b0}}, err_sq};
      cnt_d = cnt_q + {{(2*W){1'b0}}, (|stg_err_q)};
      if (stg_err_q > wce_q) begin
        wce_d   = stg_err_q;
        wce_a_d = stg_a_q;
        wce_b_d = stg_b_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mae_d   = '0;
          mse_d   = '0;
          cnt_d   = '0;
          wce_d   = '0;
          wce_a_d = '0;
          wce_b_d = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stg_err_d = abs_err;
        stg_a_d   = op_a;
        stg_b_d   = op_b;
        valid_d   = 1'b1;
        k_d       = k_q + {{(2*W-1){1'b0}}, 1'b1};
        if (k_q == {(2*W){1'b1}}) begin
          state_d = ST_DRAIN;
        end
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          k_d     = k_q;
        end
      end
      ST_DRAIN: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        done_d  = ~abort;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      stg_err_q <= '0;
      stg_a_q   <= '0;
      stg_b_q   <= '0;
      mae_q     <= '0;
      mse_q     <= '0;
      cnt_q     <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      stg_err_q <= stg_err_d;
      stg_a_q   <= stg_a_d;
      stg_b_q   <= stg_b_d;
      mae_q     <= mae_d;
      mse_q     <= mse_d;
      cnt_q     <= cnt_d;
      wce_q     <= wce_d;
      wce_a_q   <= wce_a_d;
      wce_b_q   <= wce_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mae_sum   = mae_q;
  assign mse_sum   = mse_q;
  assign err_count = cnt_q;
  assign wce       = wce_q;
  assign wce_a     = wce_a_q;
  assign wce_b     = wce_b_q;

endmodule

// File: tb/tb_add8u_err_sweeper.sv
// Bench for add8u_err_sweeper: behavioural approximate adders feed the sweeper,
// a reference model fills a result queue that is drained on done/abort.
module tb_add8u_err_sweeper;

  localparam int TW = 5;
  localparam int M  = 1 << TW;
  localparam int NP = M * M;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [TW-1:0]   op_a, op_b;
  logic [TW:0]     approx_sum;
  logic            busy, done;
  logic [3*TW:0]   mae_sum;
  logic [TW:0]     wce;
  logic [TW-1:0]   wce_a, wce_b;
  logic [2*TW:0]   err_count;
  logic [4*TW+2:0] mse_sum;

  int mode;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] mae, wce, wa, wb, cnt, mse;
  } res_t;
  res_t exp_q[$];

  add8u_err_sweeper #(.W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
    .busy(busy), .done(done), .mae_sum(mae_sum), .wce(wce),
    .wce_a(wce_a), .wce_b(wce_b), .err_count(err_count), .mse_sum(mse_sum)
  );

  always #5 clk = ~clk;

  // 0 exact, 1 stuck-zero, 2 off-by-one (mod 2^(W+1)), 3 LSB forced low
  function automatic logic [TW:0] approx_fn(int md, int a, int b);
    int s;
    s = a + b;
    case (md)
      0:       return (TW+1)'(s);
      1:       return '0;
      2:       return (TW+1)'((s + 1) % (2 * M));
      default: return (TW+1)'(s & ~1);
    endcase
  endfunction

  assign approx_sum = approx_fn(mode, int'(op_a), int'(op_b));

  function automatic res_t model(int md, int npairs);
    res_t r;
    longint mae = 0, mse = 0, cnt = 0, w = 0, wa = 0, wb = 0;
    for (int k = 0; k < npairs; k++) begin
      int a, b, ex, ap, e;
      a  = k % M;
      b  = k / M;
      ex = a + b;
      ap = int'(approx_fn(md, a, b));
      e  = (ap > ex) ? ap - ex : ex - ap;
      mae += e;
      mse += longint'(e) * longint'(e);
      if (e != 0) cnt++;
      if (e > w) begin w = e; wa = a; wb = b; end
    end
    r.mae = mae; r.mse = mse; r.cnt = cnt; r.wce = w; r.wa = wa; r.wb = wb;
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit timeout);
    cycles  = 0;
    timeout = 1'b0;
    while (done !== 1'b1) begin
      @(negedge clk);
      cycles++;
      if (cycles > NP + 50) begin timeout = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({op_a, op_b, busy, done, mae_sum, wce, wce_a, wce_b, err_count, mse_sum} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got busy=%b done=%b mae=%0d wce=%0d cnt=%0d want all 0",
                        busy, done, mae_sum, wce, err_count);
    end
    rst = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_abort got busy=%b done=%b want 0 0", busy, done);
    end
    $display("test_reset: done");
  endtask

  task automatic test_full_sweep(int md, string nm);
    int cyc; bit to; res_t r;
    mode = md;
    pulse_start();
    exp_q.push_back(model(md, NP));
    n_vec++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s.busy_rise got %b want 1", nm, busy); end
    wait_done(cyc, to);
    r = exp_q.pop_front();
    n_vec++;
    if (to || cyc != NP + 1) begin
      n_bad++; $display("FAIL %s.latency got %0d cycles (timeout=%0d) want %0d", nm, cyc, to, NP + 1);
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s.busy_fall got %b want 0", nm, busy); end
    n_vec++; if (64'(mae_sum) !== r.mae) begin n_bad++; $display("FAIL %s.mae got %0d want %0d", nm, mae_sum, r.mae); end
    n_vec++; if (64'(wce) !== r.wce) begin n_bad++; $display("FAIL %s.wce got %0d want %0d", nm, wce, r.wce); end
    n_vec++; if (64'(wce_a) !== r.wa || 64'(wce_b) !== r.wb) begin
      n_bad++; $display("FAIL %s.wce_ab got %0d,%0d want %0d,%0d", nm, wce_a, wce_b, r.wa, r.wb); end
    n_vec++; if (64'(err_count) !== r.cnt) begin n_bad++; $display("FAIL %s.cnt got %0d want %0d", nm, err_count, r.cnt); end
    n_vec++; if (64'(mse_sum) !== r.mse) begin n_bad++; $display("FAIL %s.mse got %0d want %0d", nm, mse_sum, r.mse); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL %s.done_width got %b want 0", nm, done); end
    $display("test_full_sweep %s: mae=%0d wce=%0d at (%0d,%0d) cnt=%0d mse=%0d cycles=%0d",
             nm, mae_sum, wce, wce_a, wce_b, err_count, mse_sum, cyc);
  endtask

  task automatic test_abort();
    res_t r; bit saw_done;
    mode = 1;
    pulse_start();
    for (int i = 1; i <= 99; i++) @(negedge clk);
    abort = 1'b1;
    // abort is sampled on edge t0+100, so pairs 0..98 have been accumulated
    exp_q.push_back(model(1, 99));
    @(negedge clk); abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort.stop got busy=%b done=%b want 0 0", busy, done);
    end
    saw_done = 1'b0;
    repeat (20) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    n_vec++;
    if (saw_done) begin n_bad++; $display("FAIL abort.no_done got done pulse want none"); end
    r = exp_q.pop_front();
    n_vec++; if (64'(err_count) !== r.cnt) begin n_bad++; $display("FAIL abort.cnt got %0d want %0d", err_count, r.cnt); end
    n_vec++; if (64'(mae_sum) !== r.mae) begin n_bad++; $display("FAIL abort.mae got %0d want %0d", mae_sum, r.mae); end
    n_vec++; if (64'(mse_sum) !== r.mse) begin n_bad++; $display("FAIL abort.mse got %0d want %0d", mse_sum, r.mse); end
    n_vec++; if (64'(wce) !== r.wce || 64'(wce_a) !== r.wa || 64'(wce_b) !== r.wb) begin
      n_bad++; $display("FAIL abort.wce got %0d(%0d,%0d) want %0d(%0d,%0d)", wce, wce_a, wce_b, r.wce, r.wa, r.wb); end
    $display("test_abort: partial cnt=%0d mae=%0d", err_count, mae_sum);
    test_full_sweep(1, "abort_restart");
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; res_t r;
    mode = 1;
    pulse_start();
    exp_q.push_back(model(1, NP));
    cyc = 0;
    while (done !== 1'b1 && cyc <= NP + 50) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3 || cyc == 4 || cyc == 200 || cyc == NP) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    r = exp_q.pop_front();
    n_vec++;
    if (cyc != NP + 1) begin n_bad++; $display("FAIL b2b.first_latency got %0d want %0d", cyc, NP + 1); end
    n_vec++; if (64'(mae_sum) !== r.mae || 64'(mse_sum) !== r.mse) begin
      n_bad++; $display("FAIL b2b.first_sums got mae=%0d mse=%0d want mae=%0d mse=%0d", mae_sum, mse_sum, r.mae, r.mse); end
    n_vec++; if (64'(err_count) !== r.cnt) begin n_bad++; $display("FAIL b2b.first_cnt got %0d want %0d", err_count, r.cnt); end
    // Restart from inside the done cycle with a different adder model.
    mode = 2;
    start = 1'b1;
    exp_q.push_back(model(2, NP));
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || mae_sum !== '0 || err_count !== '0 || wce !== '0) begin
      n_bad++; $display("FAIL b2b.restart got busy=%b done=%b mae=%0d cnt=%0d wce=%0d want 1 0 0 0 0",
                        busy, done, mae_sum, err_count, wce);
    end
    wait_done(cyc, to);
    r = exp_q.pop_front();
    n_vec++;
    if (to || cyc != NP + 1) begin n_bad++; $display("FAIL b2b.second_latency got %0d want %0d", cyc, NP + 1); end
    n_vec++; if (64'(mae_sum) !== r.mae || 64'(mse_sum) !== r.mse) begin
      n_bad++; $display("FAIL b2b.second_sums got mae=%0d mse=%0d want mae=%0d mse=%0d", mae_sum, mse_sum, r.mae, r.mse); end
    n_vec++; if (64'(err_count) !== r.cnt || 64'(wce) !== r.wce || 64'(wce_a) !== r.wa || 64'(wce_b) !== r.wb) begin
      n_bad++; $display("FAIL b2b.second_wce got cnt=%0d wce=%0d(%0d,%0d) want cnt=%0d wce=%0d(%0d,%0d)",
                        err_count, wce, wce_a, wce_b, r.cnt, r.wce, r.wa, r.wb); end
    $display("test_back_to_back: second sweep cnt=%0d mae=%0d", err_count, mae_sum);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit saw_done;
    mode = 1;
    pulse_start();
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({op_a, op_b, busy, done, mae_sum, wce, wce_a, wce_b, err_count, mse_sum} !== '0) begin
      n_bad++; $display("FAIL async_reset got busy=%b mae=%0d cnt=%0d op=%0d,%0d want all 0",
                        busy, mae_sum, err_count, op_a, op_b);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1; end
    n_vec++;
    if (saw_done) begin n_bad++; $display("FAIL async_reset.quiet got done/busy activity want none"); end
    $display("test_async_reset: outputs cleared mid-sweep");
    test_full_sweep(1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_full_sweep(0, "exact");
    test_full_sweep(1, "stuck_zero");
    test_full_sweep(2, "offset");
    test_full_sweep(3, "lsb_clear");
    test_abort();
    test_back_to_back();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
